// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcode constants and opcode classification
package alu_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SRC1, SRC2, EXEC, WB, DONE} state_t;
  localparam logic [3:0] OPC_ALUI_ADD = 4'd1;
  localparam logic [3:0] OPC_ALUI_SUB = 4'd2;
  localparam logic [3:0] OPC_ALUR_ADD = 4'd3;
  localparam logic [3:0] OPC_ALUR_SUB = 4'd4;
  function automatic logic is_alui(input logic [31:0] opc);
    return opc == 32'(OPC_ALUI_ADD) || opc == 32'(OPC_ALUI_SUB);
  endfunction
  function automatic logic is_alur(input logic [31:0] opc);
    return opc == 32'(OPC_ALUR_ADD) || opc == 32'(OPC_ALUR_SUB);
  endfunction
endpackage

// File: rtl/alu_seq_fsm_onehot_dec.sv
// onehot_dec: register index to one-hot enable, all zero when disabled
module onehot_dec #(
  parameter int N  = 4,
  parameter int IW = 6
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oh
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = en && (32'(idx) == i);
  end
endmodule

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: ALUI/ALUR instruction sequencer driving register, ALU and bus strobes
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 4,
  parameter int FIELD_W    = 6,
  parameter int OPC_W      = 4,
  parameter int IMM_SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [OPC_W+2*FIELD_W-1:0]   instr,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         pc_inc,
  output logic [NUM_REGS-1:0]          g_out,
  output logic [NUM_REGS-1:0]          g_in,
  output logic                         alu_in1,
  output logic                         alu_in2,
  output logic                         imm_out,
  output logic [DATA_W-1:0]            imm_data,
  output logic [OPC_W-1:0]             alu_op,
  output logic                         alu_outlatch,
  output logic                         alu_out_en
);
  localparam int INSTR_W = OPC_W + 2*FIELD_W;
  state_t state, state_n;
  logic [INSTR_W-1:0] ir;
  logic err_q, legal, alur, gout_en;
  logic [OPC_W-1:0] opc;
  logic [FIELD_W-1:0] dst, src2, gout_idx;
  logic [DATA_W-1:0] imm_ext;
  assign opc  = ir[INSTR_W-1 -: OPC_W];
  assign dst  = ir[2*FIELD_W-1 -: FIELD_W];
  assign src2 = ir[FIELD_W-1:0];
  assign alur = is_alur(32'(opc));
  // legality is judged on the live instr since it is only consulted at accept
  assign legal = 32'(instr[2*FIELD_W-1 -: FIELD_W]) < 32'(NUM_REGS) &&
                 (is_alui(32'(instr[INSTR_W-1 -: OPC_W])) ||
                  (is_alur(32'(instr[INSTR_W-1 -: OPC_W])) &&
                   32'(instr[FIELD_W-1:0]) < 32'(NUM_REGS)));
  if (FIELD_W >= DATA_W) begin : g_trunc
    assign imm_ext = src2[DATA_W-1:0];
  end else begin : g_ext
    assign imm_ext = {{(DATA_W-FIELD_W){IMM_SIGNED != 0 && src2[FIELD_W-1]}}, src2};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= state == IDLE && start && !legal;
      if (state == IDLE && start) ir <= instr;
    end
  end
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:    state_n = (start && legal) ? FETCH : IDLE;
      FETCH:   state_n = SRC1;
      SRC1:    state_n = SRC2;
      SRC2:    state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = DONE;
      default: state_n = IDLE;
    endcase
    busy         = state != IDLE;
    done         = state == DONE;
    err          = err_q;
    pc_inc       = state == FETCH;
    alu_in1      = state == SRC1;
    alu_in2      = state == SRC2;
    imm_out      = state == SRC2 && !alur;
    alu_outlatch = state == EXEC;
    alu_out_en   = state == WB;
    alu_op       = busy ? opc : '0;
    imm_data     = (state inside {SRC2, EXEC, WB, DONE}) ? imm_ext : '0;
    gout_en      = state == FETCH || state == SRC1 || (state == SRC2 && alur);
    gout_idx     = state == SRC2 ? src2 : dst;
  end
  onehot_dec #(.N(NUM_REGS), .IW(FIELD_W)) u_gout (.idx(gout_idx), .en(gout_en), .oh(g_out));
  onehot_dec #(.N(NUM_REGS), .IW(FIELD_W)) u_gin  (.idx(dst), .en(state == WB), .oh(g_in));
endmodule
